data_step_sequencer: RTL and testbench

Command sequencer that sits directly upstream of the three-digit dekatron data counter and drives its Step, Reverse, Set and In inputs. It accepts INC/DEC/LOAD/CLEAR commands over a valid/ready handshake and expands each one into correctly ordered, glitch-free control pulses. Reverse and Set are held stable around every Step edge. Completion is reported with a one-cycle Done pulse; illegal load data is reported with an Err pulse.

---
 rtl/data_seq_pkg.sv | 22 ++
 rtl/data_step_sequencer_bcd_load_check.sv | 27 ++
 rtl/data_step_sequencer.sv | 170 +++++++++++++++++
 tb/tb_data_step_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/data_seq_pkg.sv
// Shared encodings for the dekatron data-counter command sequencer.
// Opcodes, FSM state type and the BCD value limits of the three-digit counter.
package data_seq_pkg;

  localparam logic [1:0] OP_INC   = 2'b00;
  localparam logic [1:0] OP_DEC   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_GAP,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [9:0] BCD_MAX  = 10'h255;
  localparam logic [9:0] BCD_ZERO = 10'h000;

endpackage

// File: rtl/data_step_sequencer_bcd_load_check.sv
// Combinational check of a BCD load value: flags illegal digits, saturates to 255.
// Zero latency; no handshake.
module bcd_load_check
  import data_seq_pkg::*;
(
  input  logic [9:0] cmd_data,
  output logic [9:0] sat_val,
  output logic       illegal
);

  logic [1:0] hund;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       over_max;

  assign hund = cmd_data[9:8];
  assign tens = cmd_data[7:4];
  assign ones = cmd_data[3:0];

  // Anything above 255 cannot be represented by the counter, so clamp it.
  assign over_max = (hund > 2'd2) ||
                    ((hund == 2'd2) && ((tens > 4'd5) || ((tens == 4'd5) && (ones > 4'd5))));

  assign illegal = (tens > 4'd9) || (ones > 4'd9);
  assign sat_val = over_max ? BCD_MAX : cmd_data;

endmodule

// File: rtl/data_step_sequencer.sv
// Expands INC/DEC/LOAD/CLEAR commands into ordered Step/Reverse/Set/In pulses; accepts only in IDLE.
// Latency: SETUP_CYC + N*(STEP_HIGH+STEP_GAP) to Done; optional Zero flag under DATA_ZERO_FLAG_EN.
module data_step_sequencer
  import data_seq_pkg::*;
#(
  parameter int SETUP_CYC = 1,
  parameter int STEP_HIGH = 1,
  parameter int STEP_GAP  = 1,
  parameter int CNT_W     = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             CmdValid,
  output logic             CmdReady,
  input  logic [1:0]       CmdOp,
  input  logic [CNT_W-1:0] CmdCount,
  input  logic [9:0]       CmdData,
  output logic             Step,
  output logic             Reverse,
  output logic             Set,
  output logic [9:0]       In,
  input  logic [9:0]       CntOut,
  output logic             Busy,
  output logic             Done,
  output logic             Err,
  output logic             Zero
);

  localparam int TMR_W = 8;

  state_e           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_q, step_d;
  logic             rev_q, rev_d;
  logic             set_q, set_d;
  logic [9:0]       in_q, in_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [9:0]       sat_val;
  logic             illegal;

  bcd_load_check u_chk (
    .cmd_data (CmdData),
    .sat_val  (sat_val),
    .illegal  (illegal)
  );

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    cnt_d   = cnt_q;
    rev_d   = rev_q;
    set_d   = set_q;
    in_d    = in_q;
    case (state_q)
      S_IDLE: begin
        if (CmdValid) begin
          if (!CmdOp[1]) begin
            if (CmdCount == '0) begin
              state_d = S_DONE;
            end else begin
              rev_d   = (CmdOp == OP_DEC);
              cnt_d   = CmdCount;
              tmr_d   = TMR_W'(SETUP_CYC - 1);
              state_d = S_SETUP;
            end
          end else if ((CmdOp == OP_LOAD) && illegal) begin
            state_d = S_ERR;
          end else begin
            in_d    = (CmdOp == OP_LOAD) ? sat_val : BCD_ZERO;
            set_d   = 1'b1;
            cnt_d   = CNT_W'(1);
            tmr_d   = TMR_W'(SETUP_CYC - 1);
            state_d = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        if (tmr_q == '0) begin
          tmr_d   = TMR_W'(STEP_HIGH - 1);
          state_d = S_PULSE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_PULSE: begin
        if (tmr_q == '0) begin
          tmr_d   = TMR_W'(STEP_GAP - 1);
          state_d = S_GAP;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_GAP: begin
        if (tmr_q == '0) begin
          // cnt_q is at least 1 here, so the decrement cannot wrap.
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            set_d   = 1'b0;
            state_d = S_DONE;
          end else begin
            tmr_d   = TMR_W'(STEP_HIGH - 1);
            state_d = S_PULSE;
          end
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    step_d = (state_d == S_PULSE);
    done_d = (state_d == S_DONE);
    err_d  = (state_d == S_ERR);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      cnt_q   <= '0;
      step_q  <= 1'b0;
      rev_q   <= 1'b0;
      set_q   <= 1'b0;
      in_q    <= BCD_ZERO;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      rev_q   <= rev_d;
      set_q   <= set_d;
      in_q    <= in_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign CmdReady = (state_q == S_IDLE);
  assign Busy     = (state_q != S_IDLE);
  assign Step     = step_q;
  assign Reverse  = rev_q;
  assign Set      = set_q;
  assign In       = in_q;
  assign Done     = done_q;
  assign Err      = err_q;

`ifdef DATA_ZERO_FLAG_EN
  logic zero_q, zero_d;

  always_comb begin
    zero_d = zero_q;
    if (state_q == S_DONE) zero_d = (CntOut == BCD_ZERO);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) zero_q <= 1'b0;
    else        zero_q <= zero_d;
  end

  assign Zero = zero_q;
`else
  logic unused_cnt_out;
  assign unused_cnt_out = ^CntOut;
  assign Zero = 1'b0;
`endif

endmodule

// File: tb/tb_data_step_sequencer.sv
// Directed vector bench for data_step_sequencer at default timing parameters.
// Cycle k counts negedges after the accepting posedge; k=0 is the first cycle after acceptance.
module tb_data_step_sequencer;
  import data_seq_pkg::*;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       CmdValid;
  logic       CmdReady;
  logic [1:0] CmdOp;
  logic [3:0] CmdCount;
  logic [9:0] CmdData;
  logic       Step;
  logic       Reverse;
  logic       Set;
  logic [9:0] In;
  logic [9:0] CntOut;
  logic       Busy;
  logic       Done;
  logic       Err;
  logic       Zero;

  int tests = 0;
  int fails = 0;

  data_step_sequencer dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .CmdValid (CmdValid),
    .CmdReady (CmdReady),
    .CmdOp    (CmdOp),
    .CmdCount (CmdCount),
    .CmdData  (CmdData),
    .Step     (Step),
    .Reverse  (Reverse),
    .Set      (Set),
    .In       (In),
    .CntOut   (CntOut),
    .Busy     (Busy),
    .Done     (Done),
    .Err      (Err),
    .Zero     (Zero)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int k, input logic [9:0] act, input logic [9:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s k=%0d got %h want %h", name, k, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] op;
    logic [3:0] cnt;
    logic [9:0] data;
    int         n;
    bit         err;
    bit         rev;
    logic [9:0] in_v;
  } vec_t;

  vec_t vecs[14];

  task automatic reset_vals(input string tag);
    chk({tag, "_step"}, 0, Step, 0);
    chk({tag, "_rev"},  0, Reverse, 0);
    chk({tag, "_set"},  0, Set, 0);
    chk({tag, "_in"},   0, In, 10'h000);
    chk({tag, "_busy"}, 0, Busy, 0);
    chk({tag, "_done"}, 0, Done, 0);
    chk({tag, "_err"},  0, Err, 0);
    chk({tag, "_zero"}, 0, Zero, 0);
    chk({tag, "_rdy"},  0, CmdReady, 1);
  endtask

  // Called right after a negedge with the DUT idle; returns after cycle resp+1.
  task automatic run_vec(input vec_t v, input int idx);
    int    resp;
    bit    is_ld;
    string p;
    p     = $sformatf("v%0d", idx);
    is_ld = v.op[1];
    resp  = (v.err || v.n == 0) ? 0 : 1 + 2 * v.n;
    chk({p, "_rdy_pre"}, -1, CmdReady, 1);
    CmdValid = 1'b1;
    CmdOp    = v.op;
    CmdCount = v.cnt;
    CmdData  = v.data;
    @(posedge Clk);
    #1;
    CmdValid = 1'b0;
    CmdCount = 4'hF;
    CmdData  = 10'h3FF;
    for (int k = 0; k <= resp + 1; k++) begin
      @(negedge Clk);
      chk({p, "_step"}, k, Step, (!v.err && k < resp && (k % 2) == 1) ? 10'd1 : 10'd0);
      chk({p, "_set"},  k, Set,  (is_ld && !v.err && k < resp) ? 10'd1 : 10'd0);
      chk({p, "_rev"},  k, Reverse, v.rev);
      chk({p, "_in"},   k, In, v.in_v);
      chk({p, "_done"}, k, Done, (!v.err && k == resp) ? 10'd1 : 10'd0);
      chk({p, "_err"},  k, Err,  (v.err && k == resp) ? 10'd1 : 10'd0);
      chk({p, "_busy"}, k, Busy, (k <= resp) ? 10'd1 : 10'd0);
      chk({p, "_rdy"},  k, CmdReady, (k > resp) ? 10'd1 : 10'd0);
    end
    chk({p, "_zero"}, resp + 1, Zero, 0);
  endtask

  initial begin
    vecs[0]  = '{OP_INC,   4'd3,  10'h000, 3,  1'b0, 1'b0, 10'h000};
    vecs[1]  = '{OP_DEC,   4'd2,  10'h000, 2,  1'b0, 1'b1, 10'h000};
    vecs[2]  = '{OP_LOAD,  4'd7,  10'h137, 1,  1'b0, 1'b1, 10'h137};
    vecs[3]  = '{OP_LOAD,  4'd0,  10'h2A0, 0,  1'b1, 1'b1, 10'h137};
    vecs[4]  = '{OP_LOAD,  4'd0,  10'h299, 1,  1'b0, 1'b1, 10'h255};
    vecs[5]  = '{OP_INC,   4'd0,  10'h000, 0,  1'b0, 1'b1, 10'h255};
    vecs[6]  = '{OP_CLEAR, 4'd5,  10'h3FF, 1,  1'b0, 1'b1, 10'h000};
    vecs[7]  = '{OP_INC,   4'd15, 10'h000, 15, 1'b0, 1'b0, 10'h000};
    vecs[8]  = '{OP_LOAD,  4'd0,  10'h255, 1,  1'b0, 1'b0, 10'h255};
    vecs[9]  = '{OP_LOAD,  4'd0,  10'h256, 1,  1'b0, 1'b0, 10'h255};
    vecs[10] = '{OP_LOAD,  4'd0,  10'h0F9, 0,  1'b1, 1'b0, 10'h255};
    vecs[11] = '{OP_DEC,   4'd1,  10'h000, 1,  1'b0, 1'b1, 10'h255};
    vecs[12] = '{OP_LOAD,  4'd0,  10'h09A, 0,  1'b1, 1'b1, 10'h255};
    vecs[13] = '{OP_LOAD,  4'd0,  10'h199, 1,  1'b0, 1'b1, 10'h199};

    Rst_n    = 1'b0;
    CmdValid = 1'b0;
    CmdOp    = OP_INC;
    CmdCount = 4'd0;
    CmdData  = 10'h000;
    CntOut   = 10'h001;
    #1;
    reset_vals("rst_async");
    @(negedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    reset_vals("rst_idle");

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // Reset during the second Step pulse of an INC 3.
    CmdValid = 1'b1;
    CmdOp    = OP_INC;
    CmdCount = 4'd3;
    @(posedge Clk);
    #1;
    CmdValid = 1'b0;
    for (int k = 0; k <= 3; k++) @(negedge Clk);
    chk("midrst_step_before", 3, Step, 1);
    Rst_n = 1'b0;
    #1;
    reset_vals("midrst");
    @(negedge Clk);
    Rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge Clk);
      chk("midrst_no_done", k, Done, 0);
      chk("midrst_no_step", k, Step, 0);
      chk("midrst_rdy",     k, CmdReady, 1);
    end

`ifdef DATA_ZERO_FLAG_EN
    CntOut   = 10'h000;
    CmdValid = 1'b1;
    CmdOp    = OP_CLEAR;
    @(posedge Clk);
    #1;
    CmdValid = 1'b0;
    for (int k = 0; k <= 4; k++) @(negedge Clk);
    chk("zero_after_clear", 4, Zero, 1);
    CntOut   = 10'h001;
    CmdValid = 1'b1;
    CmdOp    = OP_INC;
    CmdCount = 4'd1;
    @(posedge Clk);
    #1;
    CmdValid = 1'b0;
    for (int k = 0; k <= 2; k++) @(negedge Clk);
    chk("zero_held", 2, Zero, 1);
    for (int k = 3; k <= 4; k++) @(negedge Clk);
    chk("zero_after_inc", 4, Zero, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
